uart_tx_arbiter: RTL and testbench

Shares one UART transmitter among `N_REQ` byte-stream requesters. Grants are round-robin and held per packet: once a requester wins, it keeps the transmitter until it supplies a byte marked `last`, or until it stalls longer than `GAP_TIMEOUT`. The block sits between the requesters (command responder, debug printer, etc.) and the transmitter's `valid`/`data`/`ready` handshake.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_pick.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        BUSY = 2'b10,
        NEXT = 2'b11
    } arb_state_t;

    // Width of a counter that must hold 0..max; never narrower than 1 bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin search over a request vector,
// starting at ptr and wrapping past N_REQ-1 to 0.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int  N_REQ    = 4,
    localparam int LB_N_REQ = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [LB_N_REQ-1:0] ptr,
    output logic                any,
    output logic [LB_N_REQ-1:0] idx,
    output logic [N_REQ-1:0]    onehot
);

    localparam logic [LB_N_REQ:0] N_EXT = (LB_N_REQ + 1)'(N_REQ);

    logic [LB_N_REQ:0] cand;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        // Scan from the far end back toward ptr so the nearest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (LB_N_REQ + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (req[cand[LB_N_REQ-1:0]]) begin
                any    = 1'b1;
                idx    = cand[LB_N_REQ-1:0];
                onehot = '0;
                onehot[cand[LB_N_REQ-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ requesters with
// round-robin grants held for a whole packet or until the owner stalls.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  N_REQ       = 4,
    parameter int  DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int  GAP_TIMEOUT = 100_000,
    localparam int LB_N_REQ    = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [DATA_WIDTH-1:0] req_data [N_REQ],
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    output logic                  grant_valid,
    output logic [LB_N_REQ-1:0]   grant_id,
    output logic                  timeout_pulse
);

    localparam int                  GAP_W     = cnt_width(GAP_TIMEOUT);
    localparam logic [GAP_W-1:0]    GAP_LIMIT = GAP_W'(GAP_TIMEOUT);
    localparam logic [LB_N_REQ-1:0] LAST_ID   = LB_N_REQ'(N_REQ - 1);

    arb_state_t            state_q;
    logic [LB_N_REQ-1:0]   rr_ptr_q;
    logic [LB_N_REQ-1:0]   owner_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_last_q;
    logic                  tx_valid_q;
    logic                  grant_valid_q;
    logic                  timeout_q;
    logic [GAP_W-1:0]      gap_q;

    logic                  pick_any;
    logic [LB_N_REQ-1:0]   pick_idx;
    logic [N_REQ-1:0]      pick_onehot;
    logic [LB_N_REQ-1:0]   rr_ptr_d;
    logic [GAP_W-1:0]      gap_d;
    logic                  gap_expired;
    logic                  owner_valid;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign rr_ptr_d    = (owner_q == LAST_ID) ? '0
                                              : owner_q + LB_N_REQ'(1);
    assign gap_d       = (&gap_q) ? gap_q : gap_q + GAP_W'(1);
    assign gap_expired = (GAP_TIMEOUT != 0) && (gap_d == GAP_LIMIT);
    assign owner_valid = req_valid[owner_q];

    // Ready is gated by reset so no requester sees an accept that is dropped.
    always_comb begin
        req_ready = '0;
        if (rstn) begin
            unique case (state_q)
                IDLE:    req_ready = pick_onehot;
                NEXT:    req_ready[owner_q] = 1'b1;
                default: req_ready = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            hold_data_q   <= '0;
            hold_last_q   <= 1'b0;
            tx_valid_q    <= 1'b0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            gap_q         <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        hold_data_q   <= req_data[pick_idx];
                        hold_last_q   <= req_last[pick_idx];
                        owner_q       <= pick_idx;
                        grant_valid_q <= 1'b1;
                        tx_valid_q    <= 1'b1;
                        state_q       <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (tx_ready) begin
                        if (hold_last_q) begin
                            rr_ptr_q      <= rr_ptr_d;
                            grant_valid_q <= 1'b0;
                            state_q       <= IDLE;
                        end else begin
                            gap_q   <= '0;
                            state_q <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (owner_valid) begin
                        hold_data_q <= req_data[owner_q];
                        hold_last_q <= req_last[owner_q];
                        tx_valid_q  <= 1'b1;
                        state_q     <= SEND;
                    end else begin
                        gap_q <= gap_d;
                        if (gap_expired) begin
                            timeout_q     <= 1'b1;
                            rr_ptr_q      <= rr_ptr_d;
                            grant_valid_q <= 1'b0;
                            state_q       <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_data       = hold_data_q;
    assign grant_valid   = grant_valid_q;
    assign grant_id      = owner_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed packet scenarios plus random traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int GT = 50;
    // 5 busy cycles, 1 cycle to re-arm, then GT idle cycles
    localparam int TO_DELAY = 5 + 1 + GT;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [DW-1:0] req_data [N];
    logic [N-1:0]  req_last  = '0;
    logic [N-1:0]  req_ready;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready  = 1'b1;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic          timeout_pulse;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .DATA_WIDTH  (DW),
        .GAP_TIMEOUT (GT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit rnd_mode = 1'b0;

    // model: owner (-1 = none), byte waiting for tx, frame in flight
    int            m_own = -1;
    int            m_ptr = 0;
    int            m_gap = 0;
    bit            m_have = 1'b0;
    bit            m_sent = 1'b0;
    bit            m_last = 1'b0;
    bit            m_to = 1'b0;
    logic [DW-1:0] m_byte = '0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] seen[$];
    logic [8:0]    dq [N][$];
    int            pause [N];
    int            tx_cnt = 0;
    int            busy_len = 5;
    int            hs_cyc = 0;
    int            to_gap = -1;
    logic [N-1:0]  acc = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        if (rstn) begin
            if (m_own < 0) begin
                w = winner();
                if (w >= 0) r[w] = 1'b1;
            end else if (!m_have && !m_sent) begin
                r[m_own] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic m_take(input int i);
        m_own  = i;
        m_have = 1'b1;
        m_byte = req_data[i];
        m_last = req_last[i];
        exp_q.push_back(req_data[i]);
    endtask

    task automatic m_release();
        m_ptr = (m_own + 1) % N;
        m_own = -1;
    endtask

    task automatic model_step();
        int w;
        if (!rstn) begin
            m_own  = -1;
            m_ptr  = 0;
            m_gap  = 0;
            m_have = 1'b0;
            m_sent = 1'b0;
            m_last = 1'b0;
            m_to   = 1'b0;
            m_byte = '0;
            exp_q.delete();
        end else begin
            m_to = 1'b0;
            if (m_own < 0) begin
                w = winner();
                if (w >= 0) m_take(w);
            end else if (m_have) begin
                if (tx_ready) begin
                    m_have = 1'b0;
                    m_sent = 1'b1;
                end
            end else if (m_sent) begin
                if (tx_ready) begin
                    m_sent = 1'b0;
                    m_gap  = 0;
                    if (m_last) m_release();
                end
            end else if (req_valid[m_own]) begin
                m_take(m_own);
            end else begin
                m_gap++;
                if (m_gap == GT) begin
                    m_to = 1'b1;
                    m_release();
                end
            end
        end
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (dq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i]  = dq[i][0][7:0];
                req_last[i]  = dq[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = DW'($urandom);
                req_last[i]  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic rand_drive(input int i);
        if (pause[i] > 0) begin
            pause[i]--;
            req_valid[i] = 1'b0;
        end else if (acc[i] || !req_valid[i]) begin
            if (acc[i] && !req_last[i] && $urandom_range(0, 5) == 0) begin
                pause[i]     = int'($urandom_range(20, 90));
                req_valid[i] = 1'b0;
            end else begin
                req_valid[i] = ($urandom_range(0, 2) == 0);
                req_data[i]  = DW'($urandom);
                req_last[i]  = ($urandom_range(0, 3) == 0);
            end
        end else if ($urandom_range(0, 29) == 0) begin
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] er;
        bit hs;
        @(negedge clk);
        er = m_ready();
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("tx_valid", 32'(tx_valid), 32'(m_have));
            if (m_have) chk("tx_data", 32'(tx_data), 32'(m_byte));
            chk("grant_valid", 32'(grant_valid), 32'(m_own >= 0));
            if (m_own >= 0) chk("grant_id", 32'(grant_id), 32'(m_own));
            chk("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
            if (m_to) to_gap = cyc - hs_cyc;
        end
        acc = er & req_valid;
        hs  = rstn && m_have && tx_ready;
        if (hs && chk_en) begin
            seen.push_back(tx_data);
            if (exp_q.size() > 0)
                chk("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            else
                chk("sb_pending", 32'(exp_q.size()), 32'd1);
            hs_cyc = cyc + 1;
        end
        @(posedge clk);
        cyc++;
        model_step();
        if (!rstn) chk_en = 1'b1;
        #1;
        if (!rstn) tx_cnt = 0;
        else if (hs) tx_cnt = (busy_len > 0) ? busy_len
                                             : int'($urandom_range(1, 12));
        else if (tx_cnt > 0) tx_cnt--;
        tx_ready = (tx_cnt == 0);
        for (int i = 0; i < N; i++) begin
            if (rnd_mode) rand_drive(i);
            else if (acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        end
        if (!rnd_mode) present();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (dq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (k < 400 && (m_own >= 0 || pending())) begin
            cycle();
            k++;
        end
        chk({nm, "_bound"}, 32'(k < 400), 32'd1);
        chk({nm, "_released"}, 32'(grant_valid), 32'd0);
    endtask

    task automatic chk_seq(input string nm, input int n,
                           input logic [31:0] bytes);
        chk({nm, "_count"}, 32'(seen.size()), 32'(n));
        for (int k = 0; k < n && k < seen.size(); k++)
            chk($sformatf("%s_byte%0d", nm, k), 32'(seen[k]),
                32'(bytes[8*(n-1-k) +: 8]));
        seen.delete();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({nm, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({nm, "_grant_valid"}, 32'(grant_valid), 32'd0);
        chk({nm, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({nm, "_timeout"}, 32'(timeout_pulse), 32'd0);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_data[i] = '0;
            pause[i]    = 0;
        end
        rstn = 1'b0;
        repeat (3) cycle();
        chk_reset_vals("rst");
        rstn = 1'b1;

        // single-byte packet
        dq[0].push_back(9'h1A5);
        present();
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_txv_pre", 32'(tx_valid), 32'd0);
        cycle();
        #1;
        chk("t1_txv", 32'(tx_valid), 32'd1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_gv", 32'(grant_valid), 32'd1);
        chk("t1_gid", 32'(grant_id), 32'd0);
        chk("t1_rdy_off", 32'(req_ready), 32'd0);
        cycle();
        #1;
        chk("t1_txv_fall", 32'(tx_valid), 32'd0);
        chk("t1_gv_hold", 32'(grant_valid), 32'd1);
        drain("t1");
        chk_seq("t1", 1, 32'hA5);

        // simultaneous requests, twice
        for (int r = 0; r < 2; r++) begin
            dq[1].push_back(9'h111);
            dq[3].push_back(9'h133);
            present();
            drain("t2");
            chk_seq($sformatf("t2_%0d", r), 2, 32'h1133);
        end

        // packet lock
        dq[2].push_back(9'h001);
        dq[2].push_back(9'h002);
        dq[2].push_back(9'h103);
        present();
        cycle();
        dq[0].push_back(9'h1FF);
        present();
        #1;
        chk("t3_locked", 32'(req_ready[0]), 32'd0);
        drain("t3");
        chk_seq("t3", 4, 32'h010203FF);

        // gap timeout, then req 2 is next in line
        dq[1].push_back(9'h010);
        present();
        cycle();
        dq[2].push_back(9'h122);
        dq[0].push_back(9'h10F);
        present();
        drain("t4");
        chk_seq("t4", 3, 32'h10220F);
        chk("t4_to_delay", 32'(to_gap), 32'(TO_DELAY));

        // reset while a byte is in flight
        dq[3].push_back(9'h15A);
        present();
        cycle();
        rstn = 1'b0;
        cycle();
        #1;
        chk_reset_vals("t5");
        cycle();
        rstn = 1'b1;
        dq[0].push_back(9'h177);
        present();
        drain("t5");
        chk_seq("t5", 1, 32'h77);

        // owner changes its inputs while the byte is held
        dq[1].push_back(9'h13C);
        present();
        cycle();
        req_data[1]  = 8'hC3;
        req_valid[1] = 1'b0;
        #1;
        chk("t6_data", 32'(tx_data), 32'h3C);
        drain("t6");
        chk_seq("t6", 1, 32'h3C);

        // random traffic with random frame times and rare resets
        rnd_mode = 1'b1;
        busy_len = 0;
        repeat (6000) begin
            rstn = ($urandom_range(0, 1499) != 0);
            cycle();
        end
        rstn     = 1'b1;
        rnd_mode = 1'b0;
        present();
        drain("rnd");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
